// File: rtl/cache_plru_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cache_def
// Description : Shared sizing constants and FSM encoding for the tree
//               pseudo-LRU replacement engine.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_def;

  localparam int ASSOCIATIVITY = 4;
  localparam int NUM_OF_SETS   = 256;
  localparam int INDEX_SIZE    = $clog2(NUM_OF_SETS);
  localparam int WAY_BITS      = $clog2(ASSOCIATIVITY);
  localparam int LRU_SIZE      = ASSOCIATIVITY - 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage : cache_def
`default_nettype wire

// File: rtl/cache_plru_controller_if.sv
`default_nettype none
// ============================================================================
// Interface   : cache_plru_controller_if
// Description : Access/lookup/flush bus between the cache controller
//               (master) and the PLRU replacement engine (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_plru_controller_if #(
  parameter int ASSOCIATIVITY = cache_def::ASSOCIATIVITY,
  parameter int NUM_OF_SETS   = cache_def::NUM_OF_SETS
);
  localparam int INDEX_SIZE = $clog2(NUM_OF_SETS);
  localparam int WAY_BITS   = $clog2(ASSOCIATIVITY);

  logic                     access_valid;
  logic [INDEX_SIZE-1:0]    access_index;
  logic [WAY_BITS-1:0]      access_way;
  logic                     lookup_valid;
  logic [INDEX_SIZE-1:0]    lookup_index;
  logic [ASSOCIATIVITY-1:0] valid_mask;
  logic                     lookup_ready;
  logic [WAY_BITS-1:0]      victim_way;
  logic                     victim_valid;
  logic                     flush_req;
  logic                     busy;

  modport master (
    output access_valid, access_index, access_way,
    output lookup_valid, lookup_index, valid_mask, flush_req,
    input  lookup_ready, victim_way, victim_valid, busy
  );

  modport slave (
    input  access_valid, access_index, access_way,
    input  lookup_valid, lookup_index, valid_mask, flush_req,
    output lookup_ready, victim_way, victim_valid, busy
  );

endinterface : cache_plru_controller_if
`default_nettype wire

// File: rtl/cache_plru_controller_plru_tree_logic.sv
`default_nettype none
// ============================================================================
// Module      : plru_tree_logic
// Description : Combinational tree-PLRU kernel. Produces the tree after an
//               access to way_i, and the victim way for the incoming tree
//               (lowest invalid way wins over the tree walk).
// Revision    : 1.0 - initial release
// ============================================================================
module plru_tree_logic #(
  parameter  int ASSOCIATIVITY = 4,
  localparam int WAY_BITS      = $clog2(ASSOCIATIVITY),
  localparam int LRU_SIZE      = ASSOCIATIVITY - 1
) (
  input  logic [LRU_SIZE-1:0]      tree_i,
  input  logic [WAY_BITS-1:0]      way_i,
  input  logic [ASSOCIATIVITY-1:0] valid_mask_i,
  output logic [LRU_SIZE-1:0]      tree_o,
  output logic [WAY_BITS-1:0]      victim_o
);

  // Walk the path to way_i (MSB first) and point every node away from it.
  always_comb begin
    int   node;
    logic dir;
    tree_o = tree_i;
    node   = 0;
    dir    = 1'b0;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir          = way_i[WAY_BITS-1-l];
      tree_o[node] = ~dir;
      node         = 2 * node + 1 + int'(dir);
    end
  end

  // Victim: lowest invalid way if any, otherwise follow the node bits.
  always_comb begin
    int   node;
    logic dir;
    victim_o = '0;
    node     = 0;
    dir      = 1'b0;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir                    = tree_i[node];
      victim_o[WAY_BITS-1-l] = dir;
      node                   = 2 * node + 1 + int'(dir);
    end
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
      if (!valid_mask_i[i]) victim_o = WAY_BITS'(i);
    end
  end

endmodule : plru_tree_logic
`default_nettype wire

// File: rtl/cache_plru_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_plru_controller
// Description : Per-set tree pseudo-LRU state with access update, victim
//               lookup (1-cycle latency, same-set forwarding) and a
//               multi-cycle flush sequencer that clears one set per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_plru_controller
  import cache_def::*;
#(
  parameter int ASSOCIATIVITY = cache_def::ASSOCIATIVITY,
  parameter int NUM_OF_SETS   = cache_def::NUM_OF_SETS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cache_plru_controller_if.slave  bus
);

  localparam int INDEX_SIZE = $clog2(NUM_OF_SETS);
  localparam int WAY_BITS   = $clog2(ASSOCIATIVITY);
  localparam int LRU_SIZE   = ASSOCIATIVITY - 1;
  localparam logic [INDEX_SIZE-1:0] LAST_SET = INDEX_SIZE'(NUM_OF_SETS - 1);

  state_e                  state_q;
  logic [INDEX_SIZE-1:0]   cnt_q;
  logic                    busy_q;
  logic                    victim_valid_q;
  logic [WAY_BITS-1:0]     victim_way_q;
  logic [LRU_SIZE-1:0]     tree_q [NUM_OF_SETS];

  logic                    access_en;
  logic                    lookup_en;
  logic                    fwd;
  logic [LRU_SIZE-1:0]     upd_tree;
  logic [LRU_SIZE-1:0]     lkp_tree;
  logic [WAY_BITS-1:0]     victim;
  logic [WAY_BITS-1:0]     unused_upd_victim;
  logic [LRU_SIZE-1:0]     unused_lkp_tree;

  // Requests are only honoured while idle; a flush blocks both paths.
  assign access_en = bus.access_valid && (state_q == IDLE);
  assign lookup_en = bus.lookup_valid && (state_q == IDLE);
  // Same-set access and lookup in one cycle: the lookup sees the new tree.
  assign fwd       = access_en && (bus.access_index == bus.lookup_index);
  assign lkp_tree  = fwd ? upd_tree : tree_q[bus.lookup_index];

  plru_tree_logic #(.ASSOCIATIVITY(ASSOCIATIVITY)) u_update (
    .tree_i       (tree_q[bus.access_index]),
    .way_i        (bus.access_way),
    .valid_mask_i ({ASSOCIATIVITY{1'b1}}),
    .tree_o       (upd_tree),
    .victim_o     (unused_upd_victim)
  );

  plru_tree_logic #(.ASSOCIATIVITY(ASSOCIATIVITY)) u_victim (
    .tree_i       (lkp_tree),
    .way_i        ({WAY_BITS{1'b0}}),
    .valid_mask_i (bus.valid_mask),
    .tree_o       (unused_lkp_tree),
    .victim_o     (victim)
  );

  // Control FSM, tree storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      for (int s = 0; s < NUM_OF_SETS; s++) tree_q[s] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access_en) tree_q[bus.access_index] <= upd_tree;
          victim_valid_q <= lookup_en;
          if (lookup_en) victim_way_q <= victim;
          if (bus.flush_req) begin
            state_q <= FLUSH;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        FLUSH: begin
          victim_valid_q <= 1'b0;
          tree_q[cnt_q]  <= '0;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == LAST_SET) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.lookup_ready = ~busy_q;
  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;

endmodule : cache_plru_controller
`default_nettype wire

// File: tb/tb_cache_plru_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_plru_controller
// Description : Directed self-checking bench for the PLRU replacement engine
//               (4 ways, 16 sets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_plru_controller;

  localparam int ASSOC = 4;
  localparam int SETS  = 16;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;
  int   cycles;

  cache_plru_controller_if #(.ASSOCIATIVITY(ASSOC), .NUM_OF_SETS(SETS)) bus ();

  cache_plru_controller #(.ASSOCIATIVITY(ASSOC), .NUM_OF_SETS(SETS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input int idx, input int way);
    bus.access_valid = 1'b1;
    bus.access_index = 4'(idx);
    bus.access_way   = 2'(way);
    step();
    bus.access_valid = 1'b0;
  endtask

  task automatic do_lookup(input int idx, input logic [3:0] mask, input int exp, input string tag);
    bus.lookup_valid = 1'b1;
    bus.lookup_index = 4'(idx);
    bus.valid_mask   = mask;
    step();
    bus.lookup_valid = 1'b0;
    chk({tag, "_vld"}, 32'(bus.victim_valid), 32'd1);
    chk(tag, 32'(bus.victim_way), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < SETS; i++) do_lookup(i, 4'hF, 0, tag);
  endtask

  // Count busy observations after the flush edge; bounded at 40.
  task automatic count_busy(output int n);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!bus.busy) break;
      n++;
      chk("stall_vv", 32'(bus.victim_valid), 32'd0);
      chk("stall_rdy", 32'(bus.lookup_ready), 32'd0);
    end
    bus.access_valid = 1'b0;
    bus.lookup_valid = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst_n            = 1'b0;
    bus.access_valid = 1'b0;
    bus.access_index = '0;
    bus.access_way   = '0;
    bus.lookup_valid = 1'b0;
    bus.lookup_index = '0;
    bus.valid_mask   = 4'hF;
    bus.flush_req    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.lookup_ready), 32'd1);
    chk("rst_vv", 32'(bus.victim_valid), 32'd0);
    chk("rst_way", 32'(bus.victim_way), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset tree: walk all-zero bits to way 0; strobe lasts one cycle.
    do_lookup(5, 4'hF, 0, "reset_victim");
    step();
    chk("strobe_drop", 32'(bus.victim_valid), 32'd0);

    // Set 5: way0 -> b0=1,b1=1 -> victim 2; then way2 -> b0=0,b2=1 -> victim 1.
    do_access(5, 0);
    do_lookup(5, 4'hF, 2, "s5_after_w0");
    do_access(5, 2);
    do_lookup(5, 4'hF, 1, "s5_after_w2");

    // Forwarding on set 7; set 8 untouched.
    bus.access_valid = 1'b1;
    bus.access_index = 4'd7;
    bus.access_way   = 2'd0;
    do_lookup(7, 4'hF, 2, "fwd_s7");
    bus.access_valid = 1'b0;
    do_lookup(7, 4'hF, 2, "s7_stored");
    do_lookup(8, 4'hF, 0, "s8_untouched");

    // Invalid-way preference on set 3 whose tree points to way 2.
    do_access(3, 0);
    do_lookup(3, 4'hF, 2, "s3_tree");
    do_lookup(3, 4'b1101, 1, "s3_inv1");
    do_lookup(3, 4'b0111, 3, "s3_inv3");
    do_lookup(3, 4'b0000, 0, "s3_inv_all");

    // Back-to-back lookups: one result per cycle.
    bus.lookup_valid = 1'b1;
    bus.lookup_index = 4'd5;
    bus.valid_mask   = 4'hF;
    step();
    bus.lookup_index = 4'd3;
    chk("b2b_0_vv", 32'(bus.victim_valid), 32'd1);
    chk("b2b_0_way", 32'(bus.victim_way), 32'd1);
    step();
    bus.lookup_valid = 1'b0;
    chk("b2b_1_vv", 32'(bus.victim_valid), 32'd1);
    chk("b2b_1_way", 32'(bus.victim_way), 32'd2);

    // Flush with a same-cycle access (set 12) and lookup (set 5 -> 1).
    bus.flush_req    = 1'b1;
    bus.access_valid = 1'b1;
    bus.access_index = 4'd12;
    bus.access_way   = 2'd0;
    bus.lookup_valid = 1'b1;
    bus.lookup_index = 4'd5;
    bus.valid_mask   = 4'hF;
    step();
    bus.flush_req = 1'b0;
    chk("fl_busy", 32'(bus.busy), 32'd1);
    chk("fl_lkp_vv", 32'(bus.victim_valid), 32'd1);
    chk("fl_lkp_way", 32'(bus.victim_way), 32'd1);
    // Keep accesses and lookups pending on set 9 for the whole flush.
    bus.access_index = 4'd9;
    bus.access_way   = 2'd0;
    bus.lookup_index = 4'd9;
    count_busy(cycles);
    chk("fl_len", 32'(cycles), 32'd16);
    chk("fl_ready", 32'(bus.lookup_ready), 32'd1);
    chk("fl_end_vv", 32'(bus.victim_valid), 32'd0);
    check_all_zero("post_flush");

    // Reset in the 5th busy cycle aborts the flush.
    do_access(5, 0);
    do_access(10, 1);
    do_lookup(10, 4'hF, 2, "s10_loaded");
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    chk("mf_busy", 32'(bus.busy), 32'd1);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mf_rst_busy", 32'(bus.busy), 32'd0);
    chk("mf_rst_ready", 32'(bus.lookup_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("post_rst");

    // A fresh flush runs its full length.
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    chk("fl2_busy", 32'(bus.busy), 32'd1);
    count_busy(cycles);
    chk("fl2_len", 32'(cycles), 32'd16);
    do_lookup(0, 4'hF, 0, "fl2_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_cache_plru_controller
`default_nettype wire
